// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding instruction-memory
// request at a time and fills the IF/ID register. Optional: FETCH_MISALIGN_CHECK_EN.
module if_fetch_stage #(
  parameter int                   data_size = 32,
  parameter logic [data_size-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 jump_taken,
  input  logic [data_size-1:0] PC_jump,
  input  logic [data_size-1:0] PC_added,
  output logic [data_size-1:0] PC_address,
  output logic                 im_req,
  output logic [data_size-1:0] im_addr,
  input  logic                 im_rvalid,
  input  logic [data_size-1:0] im_rdata,
  output logic [data_size-1:0] inst_ID,
  output logic [data_size-1:0] PC_ID,
  output logic                 valid_ID,
  output logic                 misalign_exc
);

  // state | meaning
  // IDLE  | post-reset, no request; moves to FETCH next cycle
  // FETCH | request outstanding at req_addr (== PC_address)
  // HOLD  | response parked in skid while IF/ID is stalled; no request
  // DRAIN | stale request still in flight at old req_addr; data dropped
  // ERR   | misaligned redirect seen; fetch halted (macro builds only)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3
`ifdef FETCH_MISALIGN_CHECK_EN
    , ERR = 3'd4
`endif
  } state_t;

  localparam logic [data_size-1:0] ALIGN_MASK = {{(data_size-2){1'b0}}, 2'b11};

  state_t               state, state_n;
  logic [data_size-1:0] req_addr, req_addr_n;
  logic [data_size-1:0] skid, skid_n;
  logic [data_size-1:0] pc_n, inst_n, pc_id_n;
  logic                 valid_n;
  logic                 misalign_q, misalign_n;
  logic [data_size-1:0] jump_tgt;
  logic                 jump_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign jump_tgt     = PC_jump;
  assign jump_bad     = |(PC_jump & ALIGN_MASK);
  assign misalign_exc = misalign_q;
`else
  // Without the check the low bits are simply dropped on a redirect.
  assign jump_tgt     = PC_jump & ~ALIGN_MASK;
  assign jump_bad     = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  assign im_addr = req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      PC_address <= RESET_PC;
      req_addr   <= RESET_PC;
      skid       <= '0;
      inst_ID    <= '0;
      PC_ID      <= '0;
      valid_ID   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_n;
      PC_address <= pc_n;
      req_addr   <= req_addr_n;
      skid       <= skid_n;
      inst_ID    <= inst_n;
      PC_ID      <= pc_id_n;
      valid_ID   <= valid_n;
      misalign_q <= misalign_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = PC_address;
    req_addr_n = req_addr;
    skid_n     = skid;
    inst_n     = inst_ID;
    pc_id_n    = PC_ID;
    valid_n    = valid_ID;
    misalign_n = misalign_q;
    im_req     = (state == FETCH) || (state == DRAIN);

    if (jump_taken) begin
      pc_n    = jump_tgt;
      valid_n = 1'b0;
      if (jump_bad) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        state_n    = ERR;
        misalign_n = 1'b1;
`endif
      end else begin
        misalign_n = 1'b0;
        case (state)
          // An unanswered request must be drained before the target is fetched.
          FETCH, DRAIN: begin
            if (im_rvalid) begin
              state_n    = FETCH;
              req_addr_n = jump_tgt;
            end else begin
              state_n = DRAIN;
            end
          end
          default: begin
            state_n    = FETCH;
            req_addr_n = jump_tgt;
          end
        endcase
      end
    end else begin
      case (state)
        IDLE: begin
          state_n    = FETCH;
          req_addr_n = PC_address;
        end
        FETCH: begin
          if (im_rvalid) begin
            if (stall) begin
              skid_n  = im_rdata;
              state_n = HOLD;
            end else begin
              inst_n     = im_rdata;
              pc_id_n    = PC_address;
              valid_n    = 1'b1;
              pc_n       = PC_added;
              req_addr_n = PC_added;
            end
          end else if (!stall) begin
            valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_n     = skid;
            pc_id_n    = PC_address;
            valid_n    = 1'b1;
            pc_n       = PC_added;
            req_addr_n = PC_added;
            state_n    = FETCH;
          end
        end
        DRAIN: begin
          if (im_rvalid) begin
            state_n    = FETCH;
            req_addr_n = PC_address;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; the PC adder and memory
// responses are driven cycle by cycle from the tasks below.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_taken;
  logic [31:0] PC_jump;
  logic [31:0] PC_added;
  logic [31:0] PC_address;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] inst_ID;
  logic [31:0] PC_ID;
  logic        valid_ID;
  logic        misalign_exc;

  int checks   = 0;
  int failures = 0;

  if_fetch_stage #(.data_size(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_taken(jump_taken),
    .PC_jump(PC_jump), .PC_added(PC_added), .PC_address(PC_address),
    .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .inst_ID(inst_ID), .PC_ID(PC_ID),
    .valid_ID(valid_ID), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  assign PC_added = PC_address + 32'd4;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] a);
    im_rvalid = 1'b1;
    im_rdata  = word_of(a);
    step();
    im_rvalid = 1'b0;
    im_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; jump_taken = 1'b0; PC_jump = 32'h0;
    im_rvalid = 1'b0; im_rdata = 32'h0;
    step(); step();
    checks++; if (PC_address !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", PC_address, 32'h0); end
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", im_req); end
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_ID); end
    checks++; if (inst_ID !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", inst_ID); end
    checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL reset_pc_id: got %h want 0", PC_ID); end
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b want 0", misalign_exc); end
    rst = 1'b0;
    step();
    checks++; if (im_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b want 1", im_req); end
    checks++; if (im_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h want 0", im_addr); end
  endtask

  task automatic test_reset_fetch();
    step();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL fetch_bubble0: got %b want 0", valid_ID); end
    respond(32'h0);
    checks++; if (inst_ID !== word_of(32'h0)) begin failures++; $display("FAIL fetch_inst0: got %h want %h", inst_ID, word_of(32'h0)); end
    checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL fetch_pcid0: got %h want 0", PC_ID); end
    checks++; if (valid_ID !== 1'b1) begin failures++; $display("FAIL fetch_valid0: got %b want 1", valid_ID); end
    checks++; if (im_addr !== 32'h4) begin failures++; $display("FAIL fetch_addr4: got %h want 4", im_addr); end
    checks++; if (PC_address !== 32'h4) begin failures++; $display("FAIL fetch_pc4: got %h want 4", PC_address); end
    step();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL fetch_bubble1: got %b want 0", valid_ID); end
    respond(32'h4);
    checks++; if (inst_ID !== word_of(32'h4)) begin failures++; $display("FAIL fetch_inst4: got %h want %h", inst_ID, word_of(32'h4)); end
    checks++; if (PC_ID !== 32'h4) begin failures++; $display("FAIL fetch_pcid4: got %h want 4", PC_ID); end
    checks++; if (im_addr !== 32'h8) begin failures++; $display("FAIL fetch_addr8: got %h want 8", im_addr); end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    step();
    checks++; if (valid_ID !== 1'b1) begin failures++; $display("FAIL stall_hold_valid: got %b want 1", valid_ID); end
    checks++; if (PC_address !== 32'h8) begin failures++; $display("FAIL stall_hold_pc: got %h want 8", PC_address); end
    checks++; if (im_req !== 1'b1) begin failures++; $display("FAIL stall_req_kept: got %b want 1", im_req); end
    respond(32'h8);
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL skid_req: got %b want 0", im_req); end
    checks++; if (PC_ID !== 32'h4) begin failures++; $display("FAIL skid_pcid: got %h want 4", PC_ID); end
    checks++; if (inst_ID !== word_of(32'h4)) begin failures++; $display("FAIL skid_inst: got %h want %h", inst_ID, word_of(32'h4)); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (im_req !== 1'b0 || PC_ID !== 32'h4) begin failures++; $display("FAIL skid_hold%0d: got req=%b pc_id=%h want req=0 pc_id=4", i, im_req, PC_ID); end
    end
    stall = 1'b0;
    step();
    checks++; if (PC_ID !== 32'h8) begin failures++; $display("FAIL release_pcid: got %h want 8", PC_ID); end
    checks++; if (inst_ID !== word_of(32'h8)) begin failures++; $display("FAIL release_inst: got %h want %h", inst_ID, word_of(32'h8)); end
    checks++; if (valid_ID !== 1'b1) begin failures++; $display("FAIL release_valid: got %b want 1", valid_ID); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'hC) begin failures++; $display("FAIL release_req: got req=%b addr=%h want req=1 addr=c", im_req, im_addr); end
    step();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL release_no_dup: got %b want 0", valid_ID); end
  endtask

  task automatic test_redirect_on_response();
    jump_taken = 1'b1; PC_jump = 32'h100;
    respond(32'hC);
    jump_taken = 1'b0;
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL redir_valid: got %b want 0", valid_ID); end
    checks++; if (PC_address !== 32'h100) begin failures++; $display("FAIL redir_pc: got %h want 100", PC_address); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin failures++; $display("FAIL redir_req: got req=%b addr=%h want req=1 addr=100", im_req, im_addr); end
    checks++; if (PC_ID !== 32'h8) begin failures++; $display("FAIL redir_pcid_kept: got %h want 8", PC_ID); end
    step();
    respond(32'h100);
    checks++; if (PC_ID !== 32'h100 || inst_ID !== word_of(32'h100) || valid_ID !== 1'b1) begin failures++; $display("FAIL redir_target: got pc_id=%h inst=%h v=%b want 100 %h 1", PC_ID, inst_ID, valid_ID, word_of(32'h100)); end
    checks++; if (im_addr !== 32'h104) begin failures++; $display("FAIL redir_next: got %h want 104", im_addr); end
  endtask

  task automatic test_drain();
    jump_taken = 1'b1; PC_jump = 32'h200;
    step();
    jump_taken = 1'b0;
    checks++; if (PC_address !== 32'h200) begin failures++; $display("FAIL drain_pc: got %h want 200", PC_address); end
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL drain_valid: got %b want 0", valid_ID); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h104) begin failures++; $display("FAIL drain_req0: got req=%b addr=%h want req=1 addr=104", im_req, im_addr); end
    for (int i = 1; i < 3; i++) begin
      step();
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h104) begin failures++; $display("FAIL drain_req%0d: got req=%b addr=%h want req=1 addr=104", i, im_req, im_addr); end
    end
    respond(32'h104);
    checks++; if (im_addr !== 32'h200 || im_req !== 1'b1) begin failures++; $display("FAIL drain_exit_addr: got req=%b addr=%h want req=1 addr=200", im_req, im_addr); end
    checks++; if (valid_ID !== 1'b0 || PC_ID !== 32'h100) begin failures++; $display("FAIL drain_discard: got v=%b pc_id=%h want v=0 pc_id=100", valid_ID, PC_ID); end
    step();
    respond(32'h200);
    checks++; if (PC_ID !== 32'h200 || inst_ID !== word_of(32'h200) || valid_ID !== 1'b1) begin failures++; $display("FAIL drain_target: got pc_id=%h inst=%h v=%b want 200 %h 1", PC_ID, inst_ID, valid_ID, word_of(32'h200)); end
  endtask

  task automatic test_jump_beats_stall();
    stall = 1'b1; jump_taken = 1'b1; PC_jump = 32'h300;
    step();
    stall = 1'b0; jump_taken = 1'b0;
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL jbs_valid: got %b want 0", valid_ID); end
    checks++; if (PC_address !== 32'h300) begin failures++; $display("FAIL jbs_pc: got %h want 300", PC_address); end
    checks++; if (im_addr !== 32'h204) begin failures++; $display("FAIL jbs_drain_addr: got %h want 204", im_addr); end
    respond(32'h204);
    checks++; if (im_addr !== 32'h300) begin failures++; $display("FAIL jbs_target_addr: got %h want 300", im_addr); end
    step();
    stall = 1'b1;
    respond(32'h300);
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL hold_jump_req0: got %b want 0", im_req); end
    jump_taken = 1'b1; PC_jump = 32'h400;
    step();
    jump_taken = 1'b0; stall = 1'b0;
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h400 || PC_address !== 32'h400) begin failures++; $display("FAIL hold_jump: got req=%b addr=%h pc=%h want 1 400 400", im_req, im_addr, PC_address); end
    step();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL hold_jump_skid_drop: got %b want 0", valid_ID); end
    respond(32'h400);
    checks++; if (PC_ID !== 32'h400 || inst_ID !== word_of(32'h400)) begin failures++; $display("FAIL hold_jump_target: got pc_id=%h inst=%h want 400 %h", PC_ID, inst_ID, word_of(32'h400)); end
  endtask

  task automatic test_misalign();
    step();
    jump_taken = 1'b1; PC_jump = 32'h102;
    respond(32'h404);
    jump_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (misalign_exc !== 1'b1 || im_req !== 1'b0 || valid_ID !== 1'b0) begin failures++; $display("FAIL err_hold%0d: got exc=%b req=%b v=%b want 1 0 0", i, misalign_exc, im_req, valid_ID); end
      step();
    end
    jump_taken = 1'b1; PC_jump = 32'h500;
    step();
    jump_taken = 1'b0;
    checks++; if (misalign_exc !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h500) begin failures++; $display("FAIL err_exit: got exc=%b req=%b addr=%h want 0 1 500", misalign_exc, im_req, im_addr); end
    step();
    respond(32'h500);
    checks++; if (PC_ID !== 32'h500 || valid_ID !== 1'b1) begin failures++; $display("FAIL err_resume: got pc_id=%h v=%b want 500 1", PC_ID, valid_ID); end
`else
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL noerr_exc: got %b want 0", misalign_exc); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h100 || PC_address !== 32'h100) begin failures++; $display("FAIL noerr_align: got req=%b addr=%h pc=%h want 1 100 100", im_req, im_addr, PC_address); end
    step();
    respond(32'h100);
    checks++; if (PC_ID !== 32'h100 || inst_ID !== word_of(32'h100) || valid_ID !== 1'b1) begin failures++; $display("FAIL noerr_resume: got pc_id=%h inst=%h v=%b want 100 %h 1", PC_ID, inst_ID, valid_ID, word_of(32'h100)); end
`endif
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1;
    step();
    checks++; if (PC_address !== 32'h0 || im_req !== 1'b0 || valid_ID !== 1'b0) begin failures++; $display("FAIL midrst_state: got pc=%h req=%b v=%b want 0 0 0", PC_address, im_req, valid_ID); end
    checks++; if (PC_ID !== 32'h0 || inst_ID !== 32'h0) begin failures++; $display("FAIL midrst_ifid: got pc_id=%h inst=%h want 0 0", PC_ID, inst_ID); end
    rst = 1'b0;
    step();
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin failures++; $display("FAIL midrst_req: got req=%b addr=%h want 1 0", im_req, im_addr); end
    step();
    respond(32'h0);
    checks++; if (PC_ID !== 32'h0 || inst_ID !== word_of(32'h0) || valid_ID !== 1'b1) begin failures++; $display("FAIL midrst_fetch: got pc_id=%h inst=%h v=%b want 0 %h 1", PC_ID, inst_ID, valid_ID, word_of(32'h0)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_fetch();
    test_stall_skid();
    test_redirect_on_response();
    test_drain();
    test_jump_beats_stall();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
